// File: rtl/uart_pkg.sv
// uart_pkg: CSR offsets, STAT bit positions and receiver FSM encodings for uart_rx_ip
package uart_pkg;
    localparam logic [3:0] OFF_DATA = 4'h0;
    localparam logic [3:0] OFF_STAT = 4'h4;
    localparam logic [3:0] OFF_CTRL = 4'h8;
    localparam int ST_OVR = 1;
    localparam int ST_FE  = 2;
    localparam int ST_PE  = 3;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: synchroniser, bit timing and frame FSM; 8N1, or 8E1 when UART_RX_PARITY_EN is defined
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_en,
    input  logic       rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_parity_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_AFTER = S_PARITY;
`else
    localparam logic [2:0] S_AFTER = S_STOP;
`endif
    // sync[1] is the synchronised line, sync[2] its previous value for edge detection
    logic [2:0]    sync;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    nbit;
    logic          perr;
    logic          rx_s, tick, tick_half;
    assign rx_s      = sync[1];
    assign tick      = cnt == CW'(CLKS_PER_BIT - 1);
    assign tick_half = cnt == CW'(CLKS_PER_BIT / 2 - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            sync         <= '1;
            state        <= S_IDLE;
            cnt          <= '0;
            nbit         <= '0;
            perr         <= 1'b0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
        end else begin
            sync         <= {sync[1:0], rx};
            cnt          <= cnt + 1'b1;
            o_valid      <= 1'b0;
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
            if (!rx_en) state <= S_IDLE;
            else case (state)
                S_IDLE: if (sync[2] && !rx_s) begin
                    state <= S_START;
                    cnt   <= '0;
                    perr  <= 1'b0;
                end
                S_START: if (tick_half) begin
                    state <= rx_s ? S_IDLE : S_DATA;
                    cnt   <= '0;
                    nbit  <= '0;
                end
                S_DATA: if (tick) begin
                    o_data <= {rx_s, o_data[7:1]};
                    nbit   <= nbit + 1'b1;
                    cnt    <= '0;
                    state  <= (nbit == 3'd7) ? S_AFTER : S_DATA;
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: if (tick) begin
                    perr  <= ^{o_data, rx_s};
                    cnt   <= '0;
                    state <= S_STOP;
                end
`endif
                S_STOP: if (tick) begin
                    o_valid      <= rx_s & ~perr;
                    o_frame_err  <= ~rx_s;
                    o_parity_err <= perr;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/uart_rx_ip.sv
// uart_rx_ip: UART receiver peripheral with RX FIFO, sticky error flags and DATA/STAT/CTRL CSRs
// Parity (8E1) and STAT.parity_err are enabled by defining UART_RX_PARITY_EN.
module uart_rx_ip
    import uart_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STRB_W       = DATA_W / 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wen,
    input  logic [STRB_W-1:0] wstrb,
    output logic              wready,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              ren,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    input  logic              i_uart_rx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]     wp, rp;
    logic [LW-1:0]     level;
    logic              rx_en, ovr, fe, pe;
    logic [7:0]        rx_data;
    logic              rx_valid, rx_fe, rx_pe;
    logic              ne, full, pop, push, stat_wr, ctrl_wr;
    logic [DATA_W-1:0] rd_word;
    logic              unused;
    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk         (clk),
        .rst         (rst),
        .rx_en       (rx_en),
        .rx          (i_uart_rx),
        .o_data      (rx_data),
        .o_valid     (rx_valid),
        .o_frame_err (rx_fe),
        .o_parity_err(rx_pe)
    );
    assign wready  = 1'b1;
    assign ne      = level != '0;
    assign full    = level == LW'(FIFO_DEPTH);
    assign pop     = ren && raddr[3:0] == OFF_DATA && ne;
    // a pop in the same cycle frees the slot the incoming byte needs
    assign push    = rx_valid && (!full || pop);
    assign stat_wr = wen && wstrb[0] && waddr[3:0] == OFF_STAT;
    assign ctrl_wr = wen && wstrb[0] && waddr[3:0] == OFF_CTRL;
    assign rd_word = raddr[3:0] == OFF_DATA ? (ne ? DATA_W'(mem[rp]) : '0) :
                     raddr[3:0] == OFF_STAT ? DATA_W'({4'(level), pe, fe, ovr, ne}) :
                     raddr[3:0] == OFF_CTRL ? DATA_W'(rx_en) : '0;
    assign unused  = ^{waddr, wdata, wstrb, raddr, rx_pe};
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= rx_data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
            wp     <= '0;
            rp     <= '0;
            level  <= '0;
            rx_en  <= 1'b1;
            ovr    <= 1'b0;
            fe     <= 1'b0;
            pe     <= 1'b0;
        end else begin
            rvalid <= ren;
            if (ren) rdata <= rd_word;
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            level <= level + LW'(push) - LW'(pop);
            ovr   <= (rx_valid && !push) | (ovr & ~(stat_wr & wdata[ST_OVR]));
            fe    <= rx_fe | (fe & ~(stat_wr & wdata[ST_FE]));
`ifdef UART_RX_PARITY_EN
            pe    <= rx_pe | (pe & ~(stat_wr & wdata[ST_PE]));
`else
            pe    <= 1'b0;
`endif
            if (ctrl_wr) rx_en <= wdata[0];
        end
    end
endmodule

// File: tb/tb_uart_rx_ip.sv
// tb_uart_rx_ip: directed table, corner-case sequences and randomized traffic against a queue model
module tb_uart_rx_ip;
    localparam int CPB = 16;
    localparam int DEPTH = 4;
    localparam logic [31:0] A_DATA = 32'h0, A_STAT = 32'h4, A_CTRL = 32'h8;
    logic        clk = 1'b0, rst = 1'b1, wen = 1'b0, ren = 1'b0, i_uart_rx = 1'b1;
    logic [31:0] waddr = '0, wdata = '0, raddr = '0;
    logic [3:0]  wstrb = '0;
    logic        wready, rvalid;
    logic [31:0] rdata;
    int          n_cmp = 0, n_bad = 0;
    logic [7:0]  q[$];
    logic        m_ovr = 1'b0, m_fe = 1'b0;
    typedef struct {
        logic [7:0] b;
        logic       stop;
        logic [7:0] stat;
        logic [7:0] data;
    } vec_t;
    vec_t vt[4];

    uart_rx_ip #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .waddr(waddr), .wdata(wdata), .wen(wen), .wstrb(wstrb),
        .wready(wready), .raddr(raddr), .ren(ren), .rdata(rdata), .rvalid(rvalid),
        .i_uart_rx(i_uart_rx)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic line_bit(input logic v);
        i_uart_rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input logic par_ok);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        line_bit(^b ^ ~par_ok);
`endif
        line_bit(stop);
        line_bit(1'b1);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        ren   = 1'b1;
        raddr = a;
        @(posedge clk);
        #1;
        ren = 1'b0;
        chk("rvalid", {31'b0, rvalid}, 32'h1);
        d = rdata;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wen   = 1'b1;
        waddr = a;
        wdata = d;
        wstrb = 4'hF;
        @(posedge clk);
        #1;
        wen   = 1'b0;
        wstrb = '0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(name, d, exp);
    endtask

    function automatic logic [31:0] m_stat();
        return {24'b0, 4'(q.size()), 1'b0, m_fe, m_ovr, q.size() != 0};
    endfunction

    initial begin
        logic [31:0] d;
        logic        seen;
        vt[0] = '{b: 8'hA5, stop: 1'b1, stat: 8'h11, data: 8'hA5};
        vt[1] = '{b: 8'h3C, stop: 1'b0, stat: 8'h04, data: 8'h00};
        vt[2] = '{b: 8'h00, stop: 1'b1, stat: 8'h11, data: 8'h00};
        vt[3] = '{b: 8'hFF, stop: 1'b1, stat: 8'h11, data: 8'hFF};
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_rvalid", {31'b0, rvalid}, 32'h0);
        chk("wready", {31'b0, wready}, 32'h1);
        rd_chk("reset_stat", A_STAT, 32'h0);
        @(posedge clk);
        #1;
        chk("rvalid_pulse", {31'b0, rvalid}, 32'h0);
        rd_chk("reset_ctrl", A_CTRL, 32'h1);
        rd_chk("empty_data", A_DATA, 32'h0);
        rd_chk("unmapped", 32'hC, 32'h0);

        for (int i = 0; i < 4; i++) begin
            send_byte(vt[i].b, vt[i].stop, 1'b1);
            rd_chk("tbl_stat", A_STAT, {24'b0, vt[i].stat});
            if (vt[i].stop) rd_chk("tbl_data", A_DATA, {24'b0, vt[i].data});
            else wr(A_STAT, 32'h4);
            rd_chk("tbl_stat_after", A_STAT, 32'h0);
        end

        i_uart_rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        i_uart_rx = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1;
        rd_chk("glitch_stat", A_STAT, 32'h0);

        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, 1'b1);
        rd_chk("ovr_stat", A_STAT, 32'h43);
        for (int i = 1; i <= 4; i++) rd_chk("ovr_data", A_DATA, 32'(i));
        rd_chk("ovr_data_empty", A_DATA, 32'h0);
        wr(A_STAT, 32'h2);
        rd_chk("ovr_clear", A_STAT, 32'h0);

        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1, 1'b1);
        seen = 1'b0;
        fork
            send_byte(8'h05, 1'b1, 1'b1);
            begin
                for (int i = 0; i < 400 && !seen; i++) begin
                    @(posedge clk);
                    #1;
                    if (dut.rx_valid) seen = 1'b1;
                end
                if (seen) begin
                    ren   = 1'b1;
                    raddr = A_DATA;
                    @(posedge clk);
                    #1;
                    ren = 1'b0;
                    chk("poppush_head", rdata, 32'h01);
                end
            end
        join
        chk("poppush_seen", {31'b0, seen}, 32'h1);
        rd_chk("poppush_stat", A_STAT, 32'h41);
        for (int i = 2; i <= 5; i++) rd_chk("popush_data", A_DATA, 32'(i));
        rd_chk("popush_stat_empty", A_STAT, 32'h0);

        wr(A_DATA, 32'hFF);
        wr(A_CTRL, 32'h0);
        rd_chk("ctrl_off", A_CTRL, 32'h0);
        send_byte(8'h5A, 1'b1, 1'b1);
        rd_chk("disabled_stat", A_STAT, 32'h0);
        wr(A_CTRL, 32'h1);
        rd_chk("ctrl_on", A_CTRL, 32'h1);
        send_byte(8'h5A, 1'b1, 1'b1);
        rd_chk("enabled_data", A_DATA, 32'h5A);

`ifdef UART_RX_PARITY_EN
        send_byte(8'h07, 1'b1, 1'b0);
        rd_chk("parity_err", A_STAT, 32'h08);
        wr(A_STAT, 32'h8);
        rd_chk("parity_clear", A_STAT, 32'h0);
        send_byte(8'h07, 1'b1, 1'b1);
        rd_chk("parity_ok_stat", A_STAT, 32'h11);
        rd_chk("parity_ok_data", A_DATA, 32'h07);
`endif

        for (int it = 0; it < 40; it++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                logic [7:0] b;
                logic good;
                b = 8'($urandom);
                good = $urandom_range(0, 7) != 0;
                send_byte(b, good, 1'b1);
                if (!good) m_fe = 1'b1;
                else if (q.size() < DEPTH) q.push_back(b);
                else m_ovr = 1'b1;
            end else if (op <= 7) begin
                logic [31:0] e;
                e = q.size() != 0 ? {24'b0, q.pop_front()} : 32'h0;
                rd_chk("rand_data", A_DATA, e);
            end else if (op == 8) begin
                rd_chk("rand_stat", A_STAT, m_stat());
            end else begin
                logic [3:0] m;
                m = 4'($urandom);
                wr(A_STAT, {28'b0, m});
                if (m[1]) m_ovr = 1'b0;
                if (m[2]) m_fe = 1'b0;
                rd_chk("rand_w1c", A_STAT, m_stat());
            end
        end
        rd_chk("rand_final_stat", A_STAT, m_stat());

        send_byte(8'h99, 1'b1, 1'b1);
        send_byte(8'h66, 1'b0, 1'b1);
        rd(A_STAT, d);
        i_uart_rx = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        #1;
        rst = 1'b1;
        i_uart_rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_rdata", rdata, 32'h0);
        chk("midrst_rvalid", {31'b0, rvalid}, 32'h0);
        rd_chk("midrst_stat", A_STAT, 32'h0);
        rd_chk("midrst_ctrl", A_CTRL, 32'h1);
        send_byte(8'hC3, 1'b1, 1'b1);
        rd_chk("midrst_data", A_DATA, 32'hC3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
